// File: rtl/countdown_timer_bcd_if.sv
// Panel-side bundle for the MM:SS countdown timer: load/start/stop controls,
// load digits, and the registered display/status outputs.
interface countdown_timer_bcd_if;
    logic       load;
    logic [3:0] ld_min_t;
    logic [3:0] ld_min_o;
    logic [3:0] ld_sec_t;
    logic [3:0] ld_sec_o;
    logic       start;
    logic       stop;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic       running;
    logic       done;
    logic       load_err;

    modport master (
        output load, ld_min_t, ld_min_o, ld_sec_t, ld_sec_o, start, stop,
        input  min_t, min_o, sec_t, sec_o, running, done, load_err
    );

    modport slave (
        input  load, ld_min_t, ld_min_o, ld_sec_t, ld_sec_o, start, stop,
        output min_t, min_o, sec_t, sec_o, running, done, load_err
    );
endinterface

// File: rtl/countdown_timer_bcd.sv
// Loadable MM:SS countdown timer: a cascade of BCD down-counters with borrow
// propagation, driven by a one-second prescaler that only advances in RUN.
module countdown_timer_bcd #(
    parameter int DIV = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    countdown_timer_bcd_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int            PW      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    min_t, min_o, sec_t, sec_o;
    logic [3:0]    min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt;
    logic          running, done, load_err;
    logic          done_nxt, load_err_nxt;
    logic          load_ok, at_zero, tick;

    assign load_ok = (bus.ld_min_t <= 4'd5) && (bus.ld_min_o <= 4'd9) &&
                     (bus.ld_sec_t <= 4'd5) && (bus.ld_sec_o <= 4'd9);
    assign at_zero = ({min_t, min_o, sec_t, sec_o} == 16'h0000);
    assign tick    = (state == RUN) && (presc == PRE_MAX);

    assign bus.min_t    = min_t;
    assign bus.min_o    = min_o;
    assign bus.sec_t    = sec_t;
    assign bus.sec_o    = sec_o;
    assign bus.running  = running;
    assign bus.done     = done;
    assign bus.load_err = load_err;

    // State, digit, prescaler and status registers; reset returns everything to 00:00 IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            presc    <= '0;
            min_t    <= 4'd0;
            min_o    <= 4'd0;
            sec_t    <= 4'd0;
            sec_o    <= 4'd0;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            min_t    <= min_t_nxt;
            min_o    <= min_o_nxt;
            sec_t    <= sec_t_nxt;
            sec_o    <= sec_o_nxt;
            running  <= (state_nxt == RUN);
            done     <= done_nxt;
            load_err <= load_err_nxt;
        end
    end

    // Next state and datapath: load beats stop beats start beats tick; a rejected load consumes the cycle.
    always_comb begin
        state_nxt    = state;
        presc_nxt    = presc;
        min_t_nxt    = min_t;
        min_o_nxt    = min_o;
        sec_t_nxt    = sec_t;
        sec_o_nxt    = sec_o;
        done_nxt     = 1'b0;
        load_err_nxt = 1'b0;

        if (bus.load) begin
            if (load_ok) begin
                min_t_nxt = bus.ld_min_t;
                min_o_nxt = bus.ld_min_o;
                sec_t_nxt = bus.ld_sec_t;
                sec_o_nxt = bus.ld_sec_o;
                presc_nxt = '0;
                state_nxt = IDLE;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (bus.stop && (state == RUN)) begin
            state_nxt = PAUSE;
        end else if (bus.start && ((state == IDLE) || (state == PAUSE)) && !at_zero) begin
            state_nxt = RUN;
        end else if (state == RUN) begin
            if (tick) begin
                presc_nxt = '0;
                if (sec_o == 4'd0) begin
                    sec_o_nxt = 4'd9;
                    if (sec_t == 4'd0) begin
                        sec_t_nxt = 4'd5;
                        if (min_o == 4'd0) begin
                            min_o_nxt = 4'd9;
                            min_t_nxt = min_t - 4'd1;
                        end else begin
                            min_o_nxt = min_o - 4'd1;
                        end
                    end else begin
                        sec_t_nxt = sec_t - 4'd1;
                    end
                end else begin
                    sec_o_nxt = sec_o - 4'd1;
                end
                if ({min_t_nxt, min_o_nxt, sec_t_nxt, sec_o_nxt} == 16'h0000) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end else begin
                presc_nxt = presc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd: a seconds-count reference model
// predicts every registered output; a monitor compares each cycle.
module tb_countdown_timer_bcd;
    localparam int DIV = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    typedef struct packed {
        logic [15:0] dig;
        logic        run;
        logic        dn;
        logic        lerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];

    int   m_secs = 0;
    int   m_mode = M_IDLE;
    int   m_cnt  = 0;

    countdown_timer_bcd_if bus();

    countdown_timer_bcd #(.DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Apply one cycle of inputs and push the model's prediction for the following edge.
    task automatic step(input logic r, input logic ld, input logic st, input logic sp,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        exp_t e;
        logic dn, le;
        @(negedge clk);
        rst = r; bus.load = ld; bus.start = st; bus.stop = sp;
        bus.ld_min_t = a; bus.ld_min_o = b; bus.ld_sec_t = c; bus.ld_sec_o = d;
        dn = 1'b0; le = 1'b0;
        if (r) begin
            m_secs = 0; m_mode = M_IDLE; m_cnt = 0;
        end else if (ld) begin
            if (a > 5 || b > 9 || c > 5 || d > 9) le = 1'b1;
            else begin
                m_secs = int'(a) * 600 + int'(b) * 60 + int'(c) * 10 + int'(d);
                m_cnt = 0; m_mode = M_IDLE;
            end
        end else if (sp && m_mode == M_RUN) begin
            m_mode = M_PAUSE;
        end else if (st && (m_mode == M_IDLE || m_mode == M_PAUSE) && m_secs != 0) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_mode = M_DONE; dn = 1'b1;
                end
            end else m_cnt = m_cnt + 1;
        end
        e.dig = to_bcd(m_secs);
        e.run = (m_mode == M_RUN);
        e.dn = dn;
        e.lerr = le;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_load(input logic [15:0] v);
        step(0, 1, 0, 0, v[15:12], v[11:8], v[7:4], v[3:0]);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] dut_dig();
        return {bus.min_t, bus.min_o, bus.sec_t, bus.sec_o};
    endfunction

    // Monitor: after each edge, pop the prediction for that edge and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("digits",   dut_dig(),              e.dig);
            chk("running",  16'(bus.running),       16'(e.run));
            chk("done",     16'(bus.done),          16'(e.dn));
            chk("load_err", 16'(bus.load_err),      16'(e.lerr));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.load = 0; bus.start = 0; bus.stop = 0;
        bus.ld_min_t = 0; bus.ld_min_o = 0; bus.ld_sec_t = 0; bus.ld_sec_o = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset_digits", dut_dig(), 16'h0000);
        chk("reset_running", 16'(bus.running), 16'h0);

        // 00:03 counts down to done at edge 12 after start
        do_load(16'h0003);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(4);  settle(); chk("cd_edge4", dut_dig(), 16'h0002);
        idle(4);  settle(); chk("cd_edge8", dut_dig(), 16'h0001);
        idle(3);  settle(); chk("cd_edge11_done", 16'(bus.done), 16'h0);
        idle(1);  settle(); chk("cd_edge12", dut_dig(), 16'h0000);
        chk("cd_edge12_done", 16'(bus.done), 16'h1);
        chk("cd_edge12_run", 16'(bus.running), 16'h0);
        idle(3);

        // Triple borrow 10:00 -> 09:59 -> 09:58
        do_load(16'h1000);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(4); settle(); chk("borrow_0959", dut_dig(), 16'h0959);
        idle(4); settle(); chk("borrow_0958", dut_dig(), 16'h0958);

        // Pause keeps prescaler: 2 RUN cycles, stop, 10 idle, start, 2 more RUN cycles
        do_load(16'h0005);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        idle(10); settle(); chk("pause_hold", dut_dig(), 16'h0005);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(1); settle(); chk("resume_1", dut_dig(), 16'h0005);
        idle(1); settle(); chk("resume_2", dut_dig(), 16'h0004);

        // Illegal loads rejected
        step(0, 1, 0, 0, 4'h0, 4'h0, 4'h6, 4'h0);
        settle(); chk("lerr_sec_t", 16'(bus.load_err), 16'h1);
        chk("lerr_keep", dut_dig(), 16'h0004);
        step(0, 1, 0, 0, 4'h0, 4'hA, 4'h0, 4'h0);
        settle(); chk("lerr_min_o", 16'(bus.load_err), 16'h1);
        idle(1); settle(); chk("lerr_pulse", 16'(bus.load_err), 16'h0);

        // Start on 00:00 ignored
        do_load(16'h0000);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        settle(); chk("start_zero", 16'(bus.running), 16'h0);

        // Load beats start while running
        do_load(16'h0009);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 4'h7);
        settle(); chk("ld_start_dig", dut_dig(), 16'h0007);
        chk("ld_start_run", 16'(bus.running), 16'h0);

        // Stop coincident with tick: no decrement, tick on first cycle after resume
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        settle(); chk("stop_tick", dut_dig(), 16'h0007);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(1); settle(); chk("tick_after_resume", dut_dig(), 16'h0006);

        // Reset mid-run at 02:37
        do_load(16'h0237);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        settle(); chk("rst_dig", dut_dig(), 16'h0000);
        chk("rst_run", 16'(bus.running), 16'h0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        settle(); chk("rst_then_start", 16'(bus.running), 16'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, ld, st, sp;
            logic [3:0] a, b, c, d;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 39) == 0);
            st = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 4) == 0) begin
                a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
                c = 4'($urandom_range(0, 15)); d = 4'($urandom_range(0, 15));
            end else begin
                a = 4'd0; b = 4'($urandom_range(0, 1));
                c = 4'($urandom_range(0, 1)); d = 4'($urandom_range(0, 9));
            end
            step(r, ld, st, sp, a, b, c, d);
        end

        idle(1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d required=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
